// File: rtl/pkt_ctrl_pkg.sv
// Shared encodings for the packet-controller register map and the scan engine FSM.
package pkt_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POLL_RD,
        POLL_CHK,
        RD_START,
        RD_END,
        SCAN,
        WR_DROP,
        RELEASE,
        WAIT_GAP
    } scan_state_e;

    localparam logic [7:0] REG_FLAG = 8'd0;
    localparam logic [7:0] REG_SOP  = 8'd1;
    localparam logic [7:0] REG_EOP  = 8'd2;
    localparam logic [7:0] REG_DROP = 8'd3;

    localparam logic [1:0]  SEL_REG = 2'b10;
    localparam logic [1:0]  SEL_PKT = 2'b00;
    localparam int unsigned BASE_AW = 10;

    function automatic logic [BASE_AW-1:0] reg_addr(input logic [7:0] idx);
        return {SEL_REG, idx};
    endfunction

    function automatic logic [BASE_AW-1:0] pkt_addr(input logic [7:0] word);
        return {SEL_PKT, word};
    endfunction

endpackage

// File: rtl/pkt_scan_engine_if.sv
// Single-port register/packet-memory bus between the scan engine and the packet controller.
interface pkt_scan_engine_if #(
    parameter int DWIDTH = 72,
    parameter int AWIDTH = 10
) ();
    logic              wea;
    logic [AWIDTH-1:0] addra;
    logic [DWIDTH-1:0] dina;
    logic [DWIDTH-1:0] douta;

    modport master (output wea, output addra, output dina, input  douta);
    modport slave  (input  wea, input  addra, input  dina, output douta);
endinterface

// File: rtl/pkt_word_matcher.sv
// Masked 64-bit compare with a sticky hit flag that spans one packet.
module pkt_word_matcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        vld_i,
    input  logic [63:0] word_i,
    input  logic [63:0] pattern_i,
    input  logic [63:0] mask_i,
    output logic        hit_o,
    output logic        hit_nxt_o
);
    logic hit_q;

    // hit_nxt_o lets the engine post the verdict on the same edge the last word is compared
    assign hit_nxt_o = hit_q | (vld_i && (((word_i ^ pattern_i) & mask_i) == 64'd0));
    assign hit_o     = hit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        hit_q <= 1'b0;
        else if (clr_i) hit_q <= 1'b0;
        else            hit_q <= hit_nxt_o;
    end
endmodule

// File: rtl/pkt_scan_engine.sv
// Processor-side agent of the packet controller: poll reg0, scan start..end for a
// masked pattern, post the drop verdict to reg3, then release the packet via reg0.
module pkt_scan_engine
    import pkt_ctrl_pkg::*;
#(
    parameter int DWIDTH   = 72,
    parameter int AWIDTH   = 10,
    parameter int POLL_GAP = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [63:0]           match_pattern,
    input  logic [63:0]           match_mask,
    pkt_scan_engine_if.master     mem,
    output logic                  done,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count
);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    // Parked on reg3 between accesses so idle cycles never touch packet memory
    localparam logic [AWIDTH-1:0] PARK = AWIDTH'(reg_addr(REG_DROP));
    localparam logic [AWIDTH-1:0] A_R0 = AWIDTH'(reg_addr(REG_FLAG));
    localparam logic [AWIDTH-1:0] A_R1 = AWIDTH'(reg_addr(REG_SOP));
    localparam logic [AWIDTH-1:0] A_R2 = AWIDTH'(reg_addr(REG_EOP));

    scan_state_e       state_q, state_d;
    logic [AWIDTH-1:0] addra_q, addra_d;
    logic [DWIDTH-1:0] dina_q, dina_d;
    logic              wea_q, wea_d;
    logic              done_q, done_d;
    logic [7:0]        start_q, start_d;
    logic [7:0]        end_q, end_d;
    logic              first_q, first_d;
    logic              drain_q, drain_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [15:0]       pkt_q, drop_q;
    logic [7:0]        scan_end;
    logic              hit, hit_nxt, pkt_inc;

    pkt_word_matcher u_match (
        .clk       (clk),
        .rst       (reset),
        .clr_i     (!en || state_q == RELEASE || state_q == IDLE),
        .vld_i     (state_q == SCAN && !first_q),
        .word_i    (mem.douta[63:0]),
        .pattern_i (match_pattern),
        .mask_i    (match_mask),
        .hit_o     (hit),
        .hit_nxt_o (hit_nxt)
    );

    // end arrives on douta during the first SCAN cycle, so it bypasses end_q there
    assign scan_end = first_q ? mem.douta[7:0] : end_q;
    assign pkt_inc  = en && (state_q == WR_DROP);

    always_comb begin
        state_d = state_q;
        addra_d = addra_q;
        wea_d   = 1'b0;
        dina_d  = '0;
        done_d  = 1'b0;
        start_d = start_q;
        end_d   = end_q;
        first_d = 1'b0;
        drain_d = 1'b0;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                state_d = POLL_RD;
                addra_d = A_R0;
            end
            POLL_RD: begin
                state_d = POLL_CHK;
                addra_d = PARK;
            end
            POLL_CHK: begin
                if (mem.douta != '0) begin
                    state_d = RD_START;
                    addra_d = A_R1;
                end else begin
                    state_d = WAIT_GAP;
                    gap_d   = '0;
                end
            end
            RD_START: begin
                state_d = RD_END;
                addra_d = A_R2;
            end
            RD_END: begin
                state_d = SCAN;
                start_d = mem.douta[7:0];
                addra_d = AWIDTH'(pkt_addr(mem.douta[7:0]));
                first_d = 1'b1;
            end
            SCAN: begin
                if (drain_q) begin
                    state_d = WR_DROP;
                    wea_d   = hit_nxt;
                    dina_d  = DWIDTH'(hit_nxt);
                end else begin
                    if (first_q) end_d = mem.douta[7:0];
                    if (start_q == scan_end) begin
                        drain_d = 1'b1;
                        addra_d = PARK;
                    end else begin
                        start_d = start_q + 8'd1;
                        addra_d = AWIDTH'(pkt_addr(start_q + 8'd1));
                    end
                end
            end
            WR_DROP: begin
                state_d = RELEASE;
                addra_d = A_R0;
                wea_d   = 1'b1;
                done_d  = 1'b1;
            end
            RELEASE: begin
                state_d = WAIT_GAP;
                addra_d = PARK;
                gap_d   = '0;
            end
            WAIT_GAP: begin
                if (gap_q == GW'(POLL_GAP - 1)) begin
                    state_d = POLL_RD;
                    addra_d = A_R0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
            addra_d = '0;
            wea_d   = 1'b0;
            dina_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addra_q <= '0;
            dina_q  <= '0;
            wea_q   <= 1'b0;
            done_q  <= 1'b0;
            start_q <= '0;
            end_q   <= '0;
            first_q <= 1'b0;
            drain_q <= 1'b0;
            gap_q   <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            wea_q   <= wea_d;
            done_q  <= done_d;
            start_q <= start_d;
            end_q   <= end_d;
            first_q <= first_d;
            drain_q <= drain_d;
            gap_q   <= gap_d;
            if (pkt_inc && pkt_q != 16'hFFFF)          pkt_q  <= pkt_q + 16'd1;
            if (pkt_inc && hit && drop_q != 16'hFFFF)  drop_q <= drop_q + 16'd1;
        end
    end

    assign mem.wea    = wea_q;
    assign mem.addra  = addra_q;
    assign mem.dina   = dina_q;
    assign done       = done_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_pkt_scan_engine.sv
// Directed bench: behavioural packet controller (AND-write reg0, 1-cycle read) around the engine.
module tb_pkt_scan_engine;
    localparam int DW = 72;
    localparam int AW = 10;
    localparam logic [AW-1:0] R0 = 10'h200;
    localparam logic [AW-1:0] R3 = 10'h203;
    localparam logic [63:0]   PAT = 64'hDEAD_BEEF_CAFE_F00D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [63:0] match_pattern = PAT;
    logic [63:0] match_mask = '1;
    logic        done;
    logic [15:0] pkt_count, drop_count;

    pkt_scan_engine_if #(.DWIDTH(DW), .AWIDTH(AW)) mif ();

    pkt_scan_engine #(.DWIDTH(DW), .AWIDTH(AW), .POLL_GAP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .match_pattern (match_pattern),
        .match_mask    (match_mask),
        .mem           (mif),
        .done          (done),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    logic [63:0] pmem [256];
    logic [63:0] regs [4];
    int          cyc = 0;
    int          rd_a[$], rd_c[$], r0_c[$];
    logic [AW-1:0] wr_a[$];
    logic [DW-1:0] wr_d[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mif.wea) begin
            wr_a.push_back(mif.addra);
            wr_d.push_back(mif.dina);
            if (mif.addra[9]) begin
                if (mif.addra[1:0] == 2'd0) regs[0] = regs[0] & mif.dina[63:0];
                else                        regs[mif.addra[1:0]] = mif.dina[63:0];
            end
        end else if (!mif.addra[9]) begin
            rd_a.push_back(int'(mif.addra[7:0]));
            rd_c.push_back(cyc);
        end else if (mif.addra == R0) begin
            r0_c.push_back(cyc);
        end
        mif.douta <= mif.addra[9] ? {8'h0, regs[mif.addra[1:0]]} : {8'h0, pmem[mif.addra[7:0]]};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_logs();
        rd_a.delete(); rd_c.delete(); r0_c.delete(); wr_a.delete(); wr_d.delete();
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    // Launch one packet and wait for done; leaves the logs for the caller to inspect.
    task automatic run_pkt(input string tag, input logic [7:0] s, input logic [7:0] e,
                           input int exp_pkt, input int exp_drop);
        bit seen;
        regs[1] = {56'h0, s};
        regs[2] = {56'h0, e};
        regs[3] = 64'h0;
        clr_logs();
        regs[0] = 64'hF;
        wait_done(400, seen);
        check({tag, "_done"}, 80'(seen), 80'd1);
        check({tag, "_pkt"}, 80'(pkt_count), 80'(exp_pkt));
        check({tag, "_drop"}, 80'(drop_count), 80'(exp_drop));
        repeat (3) @(negedge clk);
        check({tag, "_reg0"}, 80'(regs[0]), 80'd0);
    endtask

    task automatic check_reads(input string tag, input logic [7:0] s, input int n);
        check({tag, "_nrd"}, 80'(rd_a.size()), 80'(n));
        for (int i = 0; i < n && i < rd_a.size(); i++) begin
            check({tag, "_rd"}, 80'(rd_a[i]), 80'(8'(s + 8'(i))));
            check({tag, "_rdcyc"}, 80'(rd_c[i] - rd_c[0]), 80'(i));
        end
    endtask

    initial begin
        bit seen;
        int c0;
        for (int i = 0; i < 256; i++) pmem[i] = {56'h0, 8'(i)};
        for (int i = 0; i < 4; i++) regs[i] = 64'h0;
        repeat (3) @(negedge clk);

        check("rst_wea",  80'(mif.wea),   80'd0);
        check("rst_addr", 80'(mif.addra), 80'd0);
        check("rst_dina", 80'(mif.dina),  80'd0);
        check("rst_done", 80'(done),      80'd0);
        check("rst_pkt",  80'(pkt_count), 80'd0);
        check("rst_drop", 80'(drop_count), 80'd0);

        // idle polling: reg0 read every POLL_GAP+2 cycles, nothing written
        clr_logs();
        c0 = cyc;
        reset = 1'b0;
        en = 1'b1;
        repeat (30) @(negedge clk);
        check("poll_first", 80'(r0_c.size() > 0 ? r0_c[0] - c0 : -1), 80'd2);
        for (int i = 1; i < 5; i++)
            check("poll_period", 80'(r0_c.size() > i ? r0_c[i] - r0_c[i-1] : -1), 80'd6);
        check("poll_nowr", 80'(wr_a.size()), 80'd0);

        // miss: words 10..13, only the release write
        run_pkt("miss", 8'h10, 8'h13, 1, 0);
        check_reads("miss", 8'h10, 4);
        check("miss_nwr", 80'(wr_a.size()), 80'd1);
        check("miss_wra", 80'(wr_a.size() > 0 ? wr_a[0] : '0), 80'(R0));
        check("miss_wrd", 80'(wr_d.size() > 0 ? wr_d[0] : '1), 80'd0);

        // hit at word 12: drop verdict written before release
        pmem[8'h12] = PAT;
        run_pkt("hit", 8'h10, 8'h13, 2, 1);
        pmem[8'h12] = 64'h12;
        check_reads("hit", 8'h10, 4);
        check("hit_nwr", 80'(wr_a.size()), 80'd2);
        check("hit_wr0a", 80'(wr_a.size() > 1 ? wr_a[0] : '0), 80'(R3));
        check("hit_wr0d", 80'(wr_d.size() > 1 ? wr_d[0] : '0), 80'd1);
        check("hit_wr1a", 80'(wr_a.size() > 1 ? wr_a[1] : '0), 80'(R0));
        check("hit_wr1d", 80'(wr_d.size() > 1 ? wr_d[1] : '1), 80'd0);
        check("hit_reg3", 80'(regs[3]), 80'd1);

        // wrap FE..01 and single-word packet
        run_pkt("wrap", 8'hFE, 8'h01, 3, 1);
        check_reads("wrap", 8'hFE, 4);
        run_pkt("one", 8'h20, 8'h20, 4, 1);
        check_reads("one", 8'h20, 1);

        // en dropped mid-SCAN
        regs[1] = 64'h00;
        regs[2] = 64'h40;
        clr_logs();
        regs[0] = 64'hF;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rd_a.size() >= 3) seen = 1'b1;
        end
        check("en_scan", 80'(seen), 80'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_wea",  80'(mif.wea),   80'd0);
        check("en_addr", 80'(mif.addra), 80'd0);
        repeat (5) @(negedge clk);
        check("en_nowr", 80'(wr_a.size()), 80'd0);
        check("en_pkt",  80'(pkt_count), 80'd4);

        // reset while the drop write is on the bus
        pmem[5] = PAT;
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (mif.wea && mif.addra == R3) seen = 1'b1;
        end
        check("rwd_seen", 80'(seen), 80'd1);
        #1 reset = 1'b1;
        #1;
        check("rwd_wea",  80'(mif.wea),    80'd0);
        check("rwd_pkt",  80'(pkt_count),  80'd0);
        check("rwd_drop", 80'(drop_count), 80'd0);
        @(negedge clk);
        reset = 1'b0;

        // saturation: packet 00..40 with a hit completes from FFFF
        @(negedge clk);
        force dut.pkt_q = 16'hFFFF;
        @(negedge clk);
        release dut.pkt_q;
        wait_done(400, seen);
        check("sat_done", 80'(seen), 80'd1);
        check("sat_pkt",  80'(pkt_count),  80'hFFFF);
        check("sat_drop", 80'(drop_count), 80'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_scan_engine.md
PKT_SCAN_ENGINE -- requirements
Module: pkt_scan_engine

Interface
REQ-001 SHALL have parameter DWIDTH, default 72, meaning the data width of the register/packet-memory port.
REQ-002 SHALL have parameter AWIDTH, default 10, meaning the address width; addra[9]=1 selects control registers, addra[9]=0 selects packet memory.
REQ-003 SHALL have parameter POLL_GAP, default 4, meaning the idle cycles between consecutive register_0 polls.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port en, input, 1, which enables the engine; it mirrors the controller's pc_en.
REQ-007 SHALL have port match_pattern, input, 64, the compare value.
REQ-008 SHALL have port match_mask, input, 64, the compare bit mask.
REQ-009 SHALL have port wea, output, 1, the write strobe.
REQ-010 SHALL have port addra, output, AWIDTH, the access address.
REQ-011 SHALL have port dina, output, DWIDTH, the write data.
REQ-012 SHALL have port douta, input, DWIDTH, the read data, valid exactly 1 cycle after its address is presented.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse per processed packet.
REQ-014 SHALL have port pkt_count, output, 16, counting processed packets.
REQ-015 SHALL have port drop_count, output, 16, counting dropped packets.

Function
REQ-016 SHALL act as the processor-side agent of the packet controller: poll for work, scan the packet, post a drop verdict, then release.
REQ-017 SHALL encode register addresses as {1'b1, 1'b0, idx[7:0]} (idx 0..3) and packet addresses as {2'b00, word[7:0]}.
REQ-018 SHALL implement the FSM states IDLE, POLL_RD, POLL_CHK, RD_START, RD_END, SCAN, WR_DROP, RELEASE, and WAIT_GAP.
REQ-019 SHALL move IDLE->POLL_RD when en=1; en=0 in any state SHALL force IDLE on the next edge, abandoning the packet without any write.
REQ-020 In POLL_RD, SHALL present addra=reg0 with wea=0.
REQ-021 In POLL_CHK, if douta!=0 SHALL go to RD_START; otherwise SHALL go to WAIT_GAP, which waits POLL_GAP cycles and then returns to POLL_RD.
REQ-022 RD_START SHALL read reg1 and RD_END SHALL read reg2; start=douta[7:0] SHALL be captured 1 cycle after reg1 is presented, and end=douta[7:0] 1 cycle after reg2 is presented.
REQ-023 SHALL pipeline SCAN: one packet address is issued per cycle from start to end inclusive, the word address increments modulo 256, and start==end scans exactly one word.
REQ-024 SHALL flag a hit when (douta[63:0] ^ match_pattern) & match_mask == 0 on any returned word; once hit is set, it SHALL hold until the packet completes.
REQ-025 SHALL enter WR_DROP one cycle after the last address is issued, i.e. after the last word has been compared.
REQ-026 In WR_DROP, SHALL write reg3 with dina={DWIDTH-1 zeros, hit}, skipping the write when hit=0.
REQ-027 In RELEASE, SHALL write reg0 with dina=0, which clears reg0 through the controller's AND-write.
REQ-028 In RELEASE, SHALL pulse done, increment pkt_count, and increment drop_count if hit=1, then go to WAIT_GAP.
REQ-029 pkt_count and drop_count SHALL saturate at 16'hFFFF.
REQ-030 wea SHALL be high only in WR_DROP (when hit=1) and RELEASE.
REQ-031 SHALL keep addra, wea, and dina registered, with no combinational path from douta to any output.

Reset
REQ-032 SHALL asynchronously drive, on reset, state=IDLE, wea=0, addra=0, dina=0, done=0, hit=0, start/end=0, pkt_count=0, and drop_count=0.
REQ-033 Reset asserted mid-SCAN or mid-write SHALL abort immediately, and the first poll SHALL occur 2 cycles after reset deasserts with en=1.

Structure
REQ-034 SHALL place state encodings, register indices (REG_FLAG=0, REG_SOP=1, REG_EOP=2, REG_DROP=3), and the address-compose constants in shared package pkt_ctrl_pkg.
REQ-035 SHALL isolate the masked compare and hit accumulator in sub-module pkt_word_matcher.

Verification
REQ-036 With reg0=0 held, the bench SHALL observe a reg0 read repeating every POLL_GAP+2 cycles and no writes.
REQ-037 With reg0=F, reg1=10, reg2=13, and no matching word, the bench SHALL observe reads of words 10..13, no reg3 write, a reg0 write of 0, done=1, pkt_count=1, and drop_count=0.
REQ-038 With the same setup but word 12 = match_pattern under an all-ones mask, the bench SHALL observe a reg3 write of 1 before the reg0 write, and drop_count=1.
REQ-039 With reg1=FE and reg2=01, the bench SHALL observe scan addresses FE, FF, 00, 01 in consecutive cycles.
REQ-040 With en dropped mid-SCAN, the bench SHALL observe IDLE next cycle with no writes, and with reset mid-WR_DROP, wea=0 immediately and counters=0.
REQ-041 With pkt_count preloaded (via force) to FFFF, the bench SHALL observe that it remains at FFFF after one more packet completes.
